writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Shares the single X->W writeback channel among p_num_units execute units (ALU, multiplier, ...).
- Each unit presents a completed result with val/rdy. The arbiter grants one unit per cycle, round-robin, into a one-entry registered output stage that drives W.
- Sits between the execute-unit outputs and the writeback stage. Execute units keep their own X__W-style handshake unchanged.

Parameters:
p_num_units, 2, number of execute units competing for writeback (1..8)
p_data_bits, 32, width of wdata

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
x_val  in  p_num_units  per-unit result valid
x_rdy  out  p_num_units  per-unit grant/ready
x_wen  in  p_num_units  per-unit register-write enable
x_waddr  in  5*p_num_units  per-unit destination register, unit i at bits [5i+4:5i]
x_wdata  in  p_data_bits*p_num_units  per-unit result, unit i at slice i
w_val  out  1  writeback transaction valid
w_rdy  in  1  writeback stage ready
w_wen  out  1  registered wen of held transaction
w_waddr  out  5  registered destination of held transaction
w_wdata  out  p_data_bits  registered result of held transaction
w_src  out  $clog2(p_num_units) (min 1)  index of the unit that produced the held transaction (trace/debug)

Behaviour:
- State: output register {val, wen, waddr, wdata, src} and round-robin pointer ptr.
- Reset (rst=0, asynchronous): out.val=0, ptr=0. Held fields are don't-care. Outputs during reset: w_val=0, x_rdy=all 0. Reset mid-transaction discards the held entry; no partial writeback.
- accept = !out.val | w_rdy. The stage takes a new entry when empty or draining the same cycle.
- Arbitration (combinational):
  - Search x_val starting at index ptr, wrapping modulo p_num_units. The first set bit is the winner.
  - x_rdy[winner] = accept; all other x_rdy = 0. No x_val set -> x_rdy all 0.
  - x_rdy may depend on x_val. Units must not make x_val depend on x_rdy.
- Transfer into the stage when accept & |x_val:
  - next out = {1, x_wen[win], x_waddr[win], x_wdata[win], win}.
  - ptr <= (win+1) mod p_num_units. Wrap from p_num_units-1 goes to 0.
- Drain only (w_val & w_rdy, no new request): out.val <= 0.
- Stall (out.val & !w_rdy): out and ptr hold. All x_rdy = 0. w_val stays 1 with stable fields until accepted.
- Simultaneous drain and fill: the new entry replaces the old in the same edge. Sustains 1 result/cycle with 1-cycle latency (x xfer at edge n -> w_val at n..).
- ptr advances only on a grant, never on idle cycles.
- x_wen=0 results are still arbitrated and forwarded (w_wen=0), preserving completion ordering per unit.
- Fairness: with all units continuously valid and w_rdy=1, grants cycle 0,1,..,N-1,0. Any requester is granted within p_num_units grants.
- p_num_units=1 degenerates to a pipeline register; ptr stays 0.

Decomposition:
- Shared package (existing UArch or new WbPkg): typedef wb_entry_t {val, wen, waddr[4:0], wdata[p_data_bits-1:0], src}. Add a function rr_pick(req, ptr) if the package supports parameterized widths; otherwise keep it local.
- Sub-module round_robin_arb: combinational req/ptr -> one-hot grant + index. It is reusable for a future D->X issue arbiter.
- The pointer register lives in writeback_arbiter, not in the sub-module.

Test Plan:
- Reset and idle: hold rst=0 three cycles with x_val=2'b11 -> w_val=0, x_rdy=0. Release with x_val=0 -> w_val stays 0, ptr=0.
- Single request: unit1 {wen=1, waddr=5, wdata=0x0000_0042} with w_rdy=1 -> x_rdy=2'b10 same cycle. Next cycle w_val=1, w_waddr=5, w_wdata=0x42, w_src=1.
- Contention: both units valid continuously, w_rdy=1, N=2 -> grant order 0,1,0,1. w_src alternates. Back-to-back w_val=1 for 4 cycles.
- Backpressure: hold w_rdy=0 for 3 cycles with an entry held -> x_rdy=0, w_* stable, ptr unchanged. On w_rdy=1, drain and refill happen in the same cycle.
- Wrap and fairness, N=4: ptr=3, x_val=4'b1001 -> unit3 granted, ptr becomes 0. Next grant is unit0. A unit2-only request is granted immediately regardless of ptr.
- Async reset mid-stall: w_val=1, w_rdy=0, assert rst between clock edges -> w_val drops to 0 immediately. After release the held entry is gone and ptr=0.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and its round-robin picker.
// Provides the register-address width and the index-width helper.
package writeback_arbiter_pkg;

    localparam int WbAddrBits = 5;

    // Width of a unit index; never zero so a single unit still has a field.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after ptr_i,
// wrapping. Ports: req_i, ptr_i in; gnt_o (one-hot), idx_o, any_o out.
module round_robin_arb
    import writeback_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        // Lowest requester overall covers the wrapped case.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_o = 1'b1;
                idx_o = IW'(i);
            end
        end
        // Lowest requester at or above ptr overrides it.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i] && (IW'(i) >= ptr_i)) begin
                idx_o = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = any_o && (idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing one registered writeback slot among units.
// Ports: clk, rst (async, low), x_* per-unit requests, w_* held result.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter  int p_num_units = 2,
    parameter  int p_data_bits = 32,
    localparam int p_src_bits  = idx_bits(p_num_units)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [p_num_units-1:0]             x_val,
    output logic [p_num_units-1:0]             x_rdy,
    input  logic [p_num_units-1:0]             x_wen,
    input  logic [WbAddrBits*p_num_units-1:0]  x_waddr,
    input  logic [p_data_bits*p_num_units-1:0] x_wdata,
    output logic                               w_val,
    input  logic                               w_rdy,
    output logic                               w_wen,
    output logic [WbAddrBits-1:0]              w_waddr,
    output logic [p_data_bits-1:0]             w_wdata,
    output logic [p_src_bits-1:0]              w_src
);

    typedef struct packed {
        logic                   val;
        logic                   wen;
        logic [WbAddrBits-1:0]  waddr;
        logic [p_data_bits-1:0] wdata;
        logic [p_src_bits-1:0]  src;
    } wb_entry_t;

    wb_entry_t              out_q, out_d;
    logic [p_src_bits-1:0]  ptr_q, ptr_d;
    logic [p_num_units-1:0] gnt;
    logic [p_src_bits-1:0]  win;
    logic                   any;
    logic                   accept;

    round_robin_arb #(
        .N  (p_num_units),
        .IW (p_src_bits)
    ) u_rr (
        .req_i (x_val),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win),
        .any_o (any)
    );

    // Slot is free when empty or being drained this cycle.
    assign accept = !out_q.val || w_rdy;

    // Grants are suppressed while reset is held.
    assign x_rdy = rst ? (gnt & {p_num_units{accept}}) : '0;

    always_comb begin
        out_d = out_q;
        ptr_d = ptr_q;
        if (accept && any) begin
            out_d.val   = 1'b1;
            out_d.wen   = x_wen[win];
            out_d.waddr = x_waddr[int'(win)*WbAddrBits +: WbAddrBits];
            out_d.wdata = x_wdata[int'(win)*p_data_bits +: p_data_bits];
            out_d.src   = win;
            if (win == p_src_bits'(p_num_units - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + 1'b1;
            end
        end else if (accept) begin
            out_d.val = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            ptr_q <= '0;
        end else begin
            out_q <= out_d;
            ptr_q <= ptr_d;
        end
    end

    assign w_val   = out_q.val;
    assign w_wen   = out_q.wen;
    assign w_waddr = out_q.waddr;
    assign w_wdata = out_q.wdata;
    assign w_src   = out_q.src;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: directed N=2 scenarios, N=4 wrap/fairness and
// randomized traffic checked against a behavioural round-robin model.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;

    logic [1:0]  x_val2, x_rdy2, x_wen2;
    logic [9:0]  x_waddr2;
    logic [63:0] x_wdata2;
    logic        w_val2, w_rdy2, w_wen2;
    logic [4:0]  w_waddr2;
    logic [31:0] w_wdata2;
    logic [0:0]  w_src2;

    logic [3:0]   x_val4, x_rdy4, x_wen4;
    logic [19:0]  x_waddr4;
    logic [127:0] x_wdata4;
    logic         w_val4, w_rdy4, w_wen4;
    logic [4:0]   w_waddr4;
    logic [31:0]  w_wdata4;
    logic [1:0]   w_src4;

    int n_chk = 0;
    int n_err = 0;

    // Reference state for the 4-unit instance.
    bit          mv = 0;
    logic        mwen = 0;
    logic [4:0]  maddr = 0;
    logic [31:0] mdata = 0;
    int          msrc = 0;
    int          mptr = 0;

    writeback_arbiter #(.p_num_units(2), .p_data_bits(32)) dut2 (
        .clk(clk), .rst(rst),
        .x_val(x_val2), .x_rdy(x_rdy2), .x_wen(x_wen2),
        .x_waddr(x_waddr2), .x_wdata(x_wdata2),
        .w_val(w_val2), .w_rdy(w_rdy2), .w_wen(w_wen2),
        .w_waddr(w_waddr2), .w_wdata(w_wdata2), .w_src(w_src2)
    );

    writeback_arbiter #(.p_num_units(4), .p_data_bits(32)) dut4 (
        .clk(clk), .rst(rst),
        .x_val(x_val4), .x_rdy(x_rdy4), .x_wen(x_wen4),
        .x_waddr(x_waddr4), .x_wdata(x_wdata4),
        .w_val(w_val4), .w_rdy(w_rdy4), .w_wen(w_wen4),
        .w_waddr(w_waddr4), .w_wdata(w_wdata4), .w_src(w_src4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after inputs change; checks and advances the model.
    task automatic tick4();
        int win;
        bit acc;
        logic [3:0] er;
        #1;
        win = -1;
        for (int k = 0; k < 4; k++) begin
            if (win < 0 && x_val4[(mptr + k) % 4]) win = (mptr + k) % 4;
        end
        acc = !mv || w_rdy4;
        er = '0;
        if (acc && win >= 0) er[win] = 1'b1;
        chk("m_xrdy", x_rdy4, er);
        chk("m_wval", w_val4, mv);
        if (mv) begin
            chk("m_wen", w_wen4, mwen);
            chk("m_waddr", w_waddr4, maddr);
            chk("m_wdata", w_wdata4, mdata);
            chk("m_src", w_src4, msrc);
        end
        if (acc && win >= 0) begin
            mv = 1;
            mwen = x_wen4[win];
            maddr = x_waddr4[win*5 +: 5];
            mdata = x_wdata4[win*32 +: 32];
            msrc = win;
            mptr = (win + 1) % 4;
        end else if (acc) begin
            mv = 0;
        end
    endtask

    task automatic drive4(input logic [3:0] v, input logic r);
        @(negedge clk);
        x_val4 = v;
        w_rdy4 = r;
        for (int i = 0; i < 4; i++) begin
            x_wen4[i] = 1'($urandom);
            x_waddr4[i*5 +: 5] = 5'($urandom);
            x_wdata4[i*32 +: 32] = $urandom;
        end
        tick4();
    endtask

    initial begin
        rst = 1'b0;
        x_val2 = 2'b11; x_wen2 = '0; x_waddr2 = '0; x_wdata2 = '0;
        w_rdy2 = 1'b1;
        x_val4 = 4'hF; x_wen4 = '0; x_waddr4 = '0; x_wdata4 = '0;
        w_rdy4 = 1'b1;

        // Reset held with requests present.
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_wval2", w_val2, 0);
            chk("rst_xrdy2", x_rdy2, 0);
            chk("rst_wval4", w_val4, 0);
            chk("rst_xrdy4", x_rdy4, 0);
        end
        @(negedge clk);
        rst = 1'b1; x_val2 = '0; x_val4 = '0;
        #1;
        chk("idle_wval", w_val2, 0);
        chk("idle_xrdy", x_rdy2, 0);
        @(negedge clk); #1;
        chk("idle_wval_b", w_val2, 0);

        // Single request from unit 1.
        @(negedge clk);
        x_val2 = 2'b10; x_wen2 = 2'b10;
        x_waddr2 = {5'd5, 5'd0};
        x_wdata2 = {32'h0000_0042, 32'h0};
        #1;
        chk("single_rdy", x_rdy2, 2'b10);
        @(negedge clk);
        x_val2 = '0;
        #1;
        chk("single_wval", w_val2, 1);
        chk("single_wen", w_wen2, 1);
        chk("single_waddr", w_waddr2, 5);
        chk("single_wdata", w_wdata2, 32'h42);
        chk("single_src", w_src2, 1);

        // Both units valid continuously: alternate grants.
        x_wen2 = 2'b11;
        x_waddr2 = {5'd7, 5'd3};
        x_wdata2 = {32'hBBBB_0001, 32'hAAAA_0000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x_val2 = 2'b11;
            #1;
            chk("cont_rdy", x_rdy2, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                chk("cont_wval", w_val2, 1);
                chk("cont_src", w_src2, (i - 1) % 2);
                chk("cont_wdata", w_wdata2,
                    ((i - 1) % 2) ? 32'hBBBB_0001 : 32'hAAAA_0000);
            end
        end

        // Backpressure: unit0 held, pointer at 1.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            w_rdy2 = 1'b0;
            #1;
            chk("bp_rdy", x_rdy2, 0);
            chk("bp_wval", w_val2, 1);
            chk("bp_src", w_src2, 0);
            chk("bp_wdata", w_wdata2, 32'hAAAA_0000);
        end
        @(negedge clk);
        w_rdy2 = 1'b1;
        #1;
        chk("bp_rel_rdy", x_rdy2, 2'b10);
        chk("bp_rel_src", w_src2, 0);
        @(negedge clk);
        x_val2 = 2'b01;
        #1;
        chk("refill_wval", w_val2, 1);
        chk("refill_src", w_src2, 1);
        chk("refill_wdata", w_wdata2, 32'hBBBB_0001);
        chk("refill_rdy", x_rdy2, 2'b01);

        // Async reset while stalled with pointer at 1.
        @(negedge clk);
        x_val2 = 2'b11; w_rdy2 = 1'b0;
        #1;
        chk("ar_pre_wval", w_val2, 1);
        chk("ar_pre_src", w_src2, 0);
        chk("ar_pre_rdy", x_rdy2, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_wval", w_val2, 0);
        chk("ar_xrdy", x_rdy2, 0);
        @(negedge clk);
        rst = 1'b1; w_rdy2 = 1'b1;
        #1;
        chk("ar_post_wval", w_val2, 0);
        chk("ar_post_rdy", x_rdy2, 2'b01);
        @(negedge clk);
        x_val2 = '0;
        #1;
        chk("ar_post_src", w_src2, 0);
        chk("ar_post_val", w_val2, 1);

        // Four units: immediate grant, wrap, fairness.
        drive4(4'b0100, 1'b1);
        chk("u2_first", x_rdy4, 4'b0100);
        drive4(4'b1001, 1'b1);
        chk("wrap_u3", x_rdy4, 4'b1000);
        drive4(4'b1001, 1'b1);
        chk("wrap_u0", x_rdy4, 4'b0001);
        chk("wrap_src3", w_src4, 3);
        drive4(4'b0000, 1'b1);
        chk("wrap_src0", w_src4, 0);
        drive4(4'b0100, 1'b1);
        chk("u2_ptr1", x_rdy4, 4'b0100);
        repeat (8) drive4(4'b1111, 1'b1);

        // Random traffic with backpressure.
        repeat (400) begin
            drive4(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
